dna_word_packer: RTL

DNA_WORD_PACKER -- requirements
Module: dna_word_packer

---
 rtl/dna_word_packer_if.sv | 41 ++++
 rtl/dna_word_packer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dna_word_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dna_word_packer_if
//  Description : Handshake bundle for dna_word_packer. Groups the base-stream
//                input, the SRAM write-request channel and the status pulses.
//                slave  - the packer side (consumes bases, issues writes)
//                master - the producer / SRAM controller side
//  Signals     : start_i, base_i[1:0], base_valid_i, last_i  (to packer)
//                ready_o, busy_o, done_o, error_o            (from packer)
//                wr_req_o, wr_addr_o, wr_data_o              (from packer)
//                wr_ack_i                                    (to packer)
//  Revision    : 1.0  initial release
// ============================================================================
interface dna_word_packer_if #(
   parameter int SRAM_WORD_WIDTH = 24,
   parameter int SRAM_ADDR_BIT   = 10
);
   logic                       start_i;
   logic [1:0]                 base_i;
   logic                       base_valid_i;
   logic                       last_i;
   logic                       ready_o;
   logic                       busy_o;
   logic                       wr_req_o;
   logic [SRAM_ADDR_BIT-1:0]   wr_addr_o;
   logic [SRAM_WORD_WIDTH-1:0] wr_data_o;
   logic                       wr_ack_i;
   logic                       done_o;
   logic                       error_o;

   modport slave (
      input  start_i, base_i, base_valid_i, last_i, wr_ack_i,
      output ready_o, busy_o, wr_req_o, wr_addr_o, wr_data_o, done_o, error_o
   );

   modport master (
      output start_i, base_i, base_valid_i, last_i, wr_ack_i,
      input  ready_o, busy_o, wr_req_o, wr_addr_o, wr_data_o, done_o, error_o
   );
endinterface
`default_nettype wire

// File: rtl/dna_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : dna_word_packer
//  Description : Packs a stream of 2-bit nucleotide codes into SRAM words of
//                3-bit symbols. Each base becomes {1'b1, base}; the query is
//                closed by an END_CODE terminator symbol, and unused slots of
//                the final word hold END_CODE. Words are written to
//                consecutive addresses starting at 0 through a req/ack port.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - dna_word_packer_if.slave (stream in, SRAM write out,
//                         ready/busy/done/error status)
//  Revision    : 1.0  initial release
// ============================================================================
module dna_word_packer #(
   parameter int       SRAM_WORD_WIDTH = 24,
   parameter int       DNA_PER_WORD    = SRAM_WORD_WIDTH / 3,
   parameter int       SRAM_ADDR_BIT   = 10,
   parameter bit [2:0] END_CODE        = 3'b000
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   dna_word_packer_if.slave   bus
);

   localparam int SLOT_W = (DNA_PER_WORD > 1) ? $clog2(DNA_PER_WORD) : 1;

   localparam logic [SLOT_W-1:0]          SLOT_LAST = SLOT_W'(DNA_PER_WORD - 1);
   localparam logic [SRAM_ADDR_BIT-1:0]   ADDR_MAX  = '1;
   localparam logic [SRAM_WORD_WIDTH-1:0] END_WORD  = {DNA_PER_WORD{END_CODE}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                       state;
   logic [SLOT_W-1:0]            slot;
   logic [SRAM_ADDR_BIT-1:0]     addr;
   logic [SRAM_WORD_WIDTH-1:0]   word;
   // final_flag: the word in flight is the last one of the query.
   // pend_flag : the query filled its last word exactly, so one extra
   //             all-terminator word still has to follow it.
   logic                         final_flag;
   logic                         pend_flag;
   logic                         ready;
   logic                         busy;
   logic                         wr_req;
   logic                         done;
   logic                         error;

   logic [SRAM_WORD_WIDTH-1:0]   fill_word;
   logic                         slot_full;

   // Current word with the offered base merged into the current slot.
   // Slot 0 sits in the most significant symbol position.
   always_comb begin
      fill_word = word;
      for (int k = 0; k < DNA_PER_WORD; k++) begin
         if (slot == SLOT_W'(k)) begin
            fill_word[SRAM_WORD_WIDTH-1-3*k -: 3] = {1'b1, bus.base_i};
         end
      end
   end

   assign slot_full = (slot == SLOT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         slot       <= '0;
         addr       <= '0;
         word       <= '0;
         final_flag <= 1'b0;
         pend_flag  <= 1'b0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         wr_req     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         // Status pulses last exactly one cycle.
         done  <= 1'b0;
         error <= 1'b0;

         case (state)
            S_IDLE: begin
               ready  <= 1'b0;
               wr_req <= 1'b0;
               busy   <= 1'b0;
               if (bus.start_i) begin
                  state      <= S_FILL;
                  addr       <= '0;
                  slot       <= '0;
                  word       <= END_WORD;
                  final_flag <= 1'b0;
                  pend_flag  <= 1'b0;
                  ready      <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            S_FILL: begin
               // ready is always high here, so valid alone means a transfer.
               if (bus.base_valid_i) begin
                  word <= fill_word;
                  if (bus.last_i) begin
                     final_flag <= !slot_full;
                     pend_flag  <= slot_full;
                     state      <= S_WRITE;
                     ready      <= 1'b0;
                     wr_req     <= 1'b1;
                  end else if (slot_full) begin
                     state      <= S_WRITE;
                     ready      <= 1'b0;
                     wr_req     <= 1'b1;
                  end else begin
                     slot       <= slot + SLOT_W'(1);
                  end
               end
            end

            S_WRITE: begin
               if (bus.wr_ack_i) begin
                  if (final_flag) begin
                     // The final word holds the terminator: query complete.
                     state      <= S_IDLE;
                     wr_req     <= 1'b0;
                     final_flag <= 1'b0;
                     done       <= 1'b1;
                  end else if (addr == ADDR_MAX) begin
                     // More words needed but no address left.
                     state      <= S_IDLE;
                     wr_req     <= 1'b0;
                     pend_flag  <= 1'b0;
                     error      <= 1'b1;
                  end else if (pend_flag) begin
                     // Emit a terminator-only word, remaining in WRITE.
                     addr       <= addr + SRAM_ADDR_BIT'(1);
                     word       <= END_WORD;
                     pend_flag  <= 1'b0;
                     final_flag <= 1'b1;
                  end else begin
                     addr       <= addr + SRAM_ADDR_BIT'(1);
                     slot       <= '0;
                     word       <= END_WORD;
                     state      <= S_FILL;
                     wr_req     <= 1'b0;
                     ready      <= 1'b1;
                  end
               end
            end

            default: begin
               state  <= S_IDLE;
               ready  <= 1'b0;
               wr_req <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_o   = ready;
   assign bus.busy_o    = busy;
   assign bus.wr_req_o  = wr_req;
   assign bus.wr_addr_o = addr;
   assign bus.wr_data_o = word;
   assign bus.done_o    = done;
   assign bus.error_o   = error;

endmodule
`default_nettype wire
